// File: rtl/core_pipe_pkg.sv
// ==== core_pipe_pkg : shared decode-stage types and opcode constants ====
// ==== rev 1.0 ===========================================================
`default_nettype none

package core_pipe_pkg;

  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_t;

  typedef enum logic [0:0] {
    ST_RUN,
    ST_HALT
  } dec_state_t;

  function automatic logic opc_legal(input logic [4:0] opc);
    logic ok;
    ok = 1'b0;
    case (opc)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32,
      OPC_STORE, OPC_OP, OPC_LUI, OPC_OP_32, OPC_BRANCH, OPC_JALR,
      OPC_JAL, OPC_SYSTEM: ok = 1'b1;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_pipe_decode_imm.sv
// ==== core_pipe_decode_imm : 32-bit immediate format select and sign-extend ====
// ==== rev 1.0 ==================================================================
`default_nettype none

module core_pipe_decode_imm
  import core_pipe_pkg::*;
#(
  parameter int XL = 63
) (
  input  logic [31:0] instr,
  output imm_fmt_t    fmt,
  output logic [XL:0] imm
);

  logic [31:0] imm32;
  logic        unused_quadrant;

  assign unused_quadrant = &{1'b0, instr[1:0]};

  always_comb begin
    fmt = IMM_NONE;
    case (instr[6:2])
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_OP_IMM_32,
      OPC_JALR, OPC_SYSTEM:   fmt = IMM_I;
      OPC_STORE:              fmt = IMM_S;
      OPC_BRANCH:             fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:     fmt = IMM_U;
      OPC_JAL:                fmt = IMM_J;
      default:                fmt = IMM_NONE;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = {{(XL-31){imm32[31]}}, imm32};

endmodule

`default_nettype wire

// File: rtl/core_pipe_decode.sv
// ==== core_pipe_decode : decode stage with PC tracking and 1-entry s2 register ====
// ==== rev 1.0 =====================================================================
`default_nettype none

module core_pipe_decode
  import core_pipe_pkg::*;
#(
  parameter int          XL               = 63,
  parameter logic [XL:0] PC_RESET_ADDRESS = 'h10000000
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        cf_valid,
  input  logic        cf_ack,
  input  logic [XL:0] cf_target,
  input  logic        s1_i16bit,
  input  logic        s1_i32bit,
  input  logic [31:0] s1_instr,
  input  logic [1:0]  s1_ferr,
  output logic        s1_eat_2,
  output logic        s1_eat_4,
  output logic        s2_valid,
  input  logic        s2_ready,
  output logic [XL:0] s2_pc,
  output logic [XL:0] s2_npc,
  output logic [31:0] s2_instr,
  output logic        s2_i16bit,
  output logic [4:0]  s2_rs1,
  output logic [4:0]  s2_rs2,
  output logic [4:0]  s2_rd,
  output logic [XL:0] s2_imm,
  output logic        s2_ferr,
  output logic        s2_illegal
);

  localparam logic [XL:0] PC_INC2 = {{(XL-1){1'b0}}, 2'd2};
  localparam logic [XL:0] PC_INC4 = {{(XL-2){1'b0}}, 3'd4};

  // Reset asserts asynchronously, releases two edges later in the g_clk domain.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  dec_state_t  state_q, state_d;
  logic [XL:0] pc_q, pc_d;
  logic        s2_valid_q, s2_valid_d;
  logic [XL:0] s2_pc_q, s2_pc_d, s2_npc_q, s2_npc_d, s2_imm_q, s2_imm_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic        s2_i16bit_q, s2_i16bit_d, s2_ferr_q, s2_ferr_d;
  logic        s2_illegal_q, s2_illegal_d;
  logic [4:0]  s2_rs1_q, s2_rs1_d, s2_rs2_q, s2_rs2_d, s2_rd_q, s2_rd_d;

  logic        e_cf, accept, eat_2, eat_4;
  logic [31:0] dec_instr;
  logic [4:0]  dec_rs1, dec_rs2;
  logic [XL:0] dec_imm, imm32_ext;
  logic        dec_ferr, dec_illegal;
  imm_fmt_t    unused_imm_fmt;

  core_pipe_decode_imm #(
    .XL (XL)
  ) u_imm (
    .instr (s1_instr),
    .fmt   (unused_imm_fmt),
    .imm   (imm32_ext)
  );

  // 16-bit wins if fetch ever raises both, keeping the eats one-hot.
  always_comb begin
    e_cf   = cf_valid && cf_ack;
    accept = rst_n && (!s2_valid_q || s2_ready) && (state_q == ST_RUN) && !e_cf;
    eat_2  = s1_i16bit && accept;
    eat_4  = s1_i32bit && !s1_i16bit && accept;
  end

  assign s1_eat_2 = eat_2;
  assign s1_eat_4 = eat_4;

  always_comb begin
    if (s1_i16bit) begin
      dec_instr   = {16'h0000, s1_instr[15:0]};
      dec_rs1     = s1_instr[11:7];
      dec_rs2     = s1_instr[6:2];
      dec_imm     = '0;
      dec_ferr    = s1_ferr[0];
      dec_illegal = (s1_instr[15:0] == 16'h0000);
    end else begin
      dec_instr   = s1_instr;
      dec_rs1     = s1_instr[19:15];
      dec_rs2     = s1_instr[24:20];
      dec_imm     = imm32_ext;
      dec_ferr    = |s1_ferr;
      dec_illegal = !opc_legal(s1_instr[6:2]);
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    s2_valid_d   = s2_valid_q;
    s2_pc_d      = s2_pc_q;
    s2_npc_d     = s2_npc_q;
    s2_instr_d   = s2_instr_q;
    s2_i16bit_d  = s2_i16bit_q;
    s2_rs1_d     = s2_rs1_q;
    s2_rs2_d     = s2_rs2_q;
    s2_rd_d      = s2_rd_q;
    s2_imm_d     = s2_imm_q;
    s2_ferr_d    = s2_ferr_q;
    s2_illegal_d = s2_illegal_q;

    if (e_cf) begin
      pc_d       = cf_target;
      s2_valid_d = 1'b0;
      state_d    = ST_RUN;
    end else if (eat_2 || eat_4) begin
      pc_d         = pc_q + (eat_2 ? PC_INC2 : PC_INC4);
      s2_valid_d   = 1'b1;
      s2_pc_d      = pc_q;
      s2_npc_d     = pc_q + (eat_2 ? PC_INC2 : PC_INC4);
      s2_instr_d   = dec_instr;
      s2_i16bit_d  = eat_2;
      s2_rs1_d     = dec_rs1;
      s2_rs2_d     = dec_rs2;
      s2_rd_d      = s1_instr[11:7];
      s2_imm_d     = dec_imm;
      s2_ferr_d    = dec_ferr;
      s2_illegal_d = dec_illegal;
      if (dec_ferr || dec_illegal) state_d = ST_HALT;
    end else if (s2_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge g_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      pc_q         <= PC_RESET_ADDRESS;
      s2_valid_q   <= 1'b0;
      s2_pc_q      <= '0;
      s2_npc_q     <= '0;
      s2_instr_q   <= '0;
      s2_i16bit_q  <= 1'b0;
      s2_rs1_q     <= '0;
      s2_rs2_q     <= '0;
      s2_rd_q      <= '0;
      s2_imm_q     <= '0;
      s2_ferr_q    <= 1'b0;
      s2_illegal_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      s2_valid_q   <= s2_valid_d;
      s2_pc_q      <= s2_pc_d;
      s2_npc_q     <= s2_npc_d;
      s2_instr_q   <= s2_instr_d;
      s2_i16bit_q  <= s2_i16bit_d;
      s2_rs1_q     <= s2_rs1_d;
      s2_rs2_q     <= s2_rs2_d;
      s2_rd_q      <= s2_rd_d;
      s2_imm_q     <= s2_imm_d;
      s2_ferr_q    <= s2_ferr_d;
      s2_illegal_q <= s2_illegal_d;
    end
  end

  assign s2_valid   = s2_valid_q;
  assign s2_pc      = s2_pc_q;
  assign s2_npc     = s2_npc_q;
  assign s2_instr   = s2_instr_q;
  assign s2_i16bit  = s2_i16bit_q;
  assign s2_rs1     = s2_rs1_q;
  assign s2_rs2     = s2_rs2_q;
  assign s2_rd      = s2_rd_q;
  assign s2_imm     = s2_imm_q;
  assign s2_ferr    = s2_ferr_q;
  assign s2_illegal = s2_illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_core_pipe_decode.sv
// ==== tb_core_pipe_decode : directed + random bench against a transaction-level model ====
// ==== rev 1.0 ==========================================================================
`default_nettype none

module tb_core_pipe_decode;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        cf_valid = 1'b0, cf_ack = 1'b0;
  logic [63:0] cf_target = '0;
  logic        s1_i16bit = 1'b0, s1_i32bit = 1'b0;
  logic [31:0] s1_instr = '0;
  logic [1:0]  s1_ferr = '0;
  logic        s1_eat_2, s1_eat_4, s2_valid;
  logic        s2_ready = 1'b0;
  logic [63:0] s2_pc, s2_npc, s2_imm;
  logic [31:0] s2_instr;
  logic        s2_i16bit, s2_ferr, s2_illegal;
  logic [4:0]  s2_rs1, s2_rs2, s2_rd;

  core_pipe_decode #(
    .XL               (63),
    .PC_RESET_ADDRESS (64'h10000000)
  ) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .cf_valid   (cf_valid),
    .cf_ack     (cf_ack),
    .cf_target  (cf_target),
    .s1_i16bit  (s1_i16bit),
    .s1_i32bit  (s1_i32bit),
    .s1_instr   (s1_instr),
    .s1_ferr    (s1_ferr),
    .s1_eat_2   (s1_eat_2),
    .s1_eat_4   (s1_eat_4),
    .s2_valid   (s2_valid),
    .s2_ready   (s2_ready),
    .s2_pc      (s2_pc),
    .s2_npc     (s2_npc),
    .s2_instr   (s2_instr),
    .s2_i16bit  (s2_i16bit),
    .s2_rs1     (s2_rs1),
    .s2_rs2     (s2_rs2),
    .s2_rd      (s2_rd),
    .s2_imm     (s2_imm),
    .s2_ferr    (s2_ferr),
    .s2_illegal (s2_illegal)
  );

  always #5 g_clk = ~g_clk;

  int passed = 0;
  int total  = 0;

  // Reference state: architectural PC, halt flag and the contents of the s2 slot.
  logic [63:0] m_pc, m_s2_pc, m_s2_npc, m_s2_imm;
  logic [31:0] m_s2_instr;
  logic        m_v, m_halt, m_s2_i16, m_s2_ferr, m_s2_ill;
  logic [4:0]  m_s2_rs1, m_s2_rs2, m_s2_rd;

  logic [4:0] legal_ops [13] = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                 5'b01000, 5'b01100, 5'b01101, 5'b01110, 5'b11000,
                                 5'b11001, 5'b11011, 5'b11100};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic is_legal(input logic [4:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 13; i++) if (legal_ops[i] == op) hit = 1'b1;
    return hit;
  endfunction

  // Immediates built by placing the field at the top of a 64-bit word and arithmetic-shifting down.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins);
    logic [63:0] t;
    logic [4:0]  op;
    op = ins[6:2];
    t  = '0;
    case (op)
      5'b00000, 5'b00011, 5'b00100, 5'b00110, 5'b11001, 5'b11100: begin
        t = {ins[31:20], 52'b0};                 return $signed(t) >>> 52;
      end
      5'b01000: begin
        t = {ins[31:25], ins[11:7], 52'b0};      return $signed(t) >>> 52;
      end
      5'b11000: begin
        t = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 51'b0};
        return $signed(t) >>> 51;
      end
      5'b01101, 5'b00101: begin
        t = {ins[31:12], 44'b0};                 return $signed(t) >>> 32;
      end
      5'b11011: begin
        t = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 43'b0};
        return $signed(t) >>> 43;
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 64'h10000000; m_v = 0; m_halt = 0;
    m_s2_pc = 0; m_s2_npc = 0; m_s2_imm = 0; m_s2_instr = 0;
    m_s2_i16 = 0; m_s2_ferr = 0; m_s2_ill = 0;
    m_s2_rs1 = 0; m_s2_rs2 = 0; m_s2_rd = 0;
  endtask

  function automatic logic model_takes();
    return !m_halt && (!m_v || s2_ready) && !(cf_valid && cf_ack);
  endfunction

  task automatic check_outputs();
    chk("eat_2",      s1_eat_2,   model_takes() && s1_i16bit);
    chk("eat_4",      s1_eat_4,   model_takes() && s1_i32bit && !s1_i16bit);
    chk("s2_valid",   s2_valid,   m_v);
    chk("s2_pc",      s2_pc,      m_s2_pc);
    chk("s2_npc",     s2_npc,     m_s2_npc);
    chk("s2_instr",   s2_instr,   m_s2_instr);
    chk("s2_i16bit",  s2_i16bit,  m_s2_i16);
    chk("s2_rs1",     s2_rs1,     m_s2_rs1);
    chk("s2_rs2",     s2_rs2,     m_s2_rs2);
    chk("s2_rd",      s2_rd,      m_s2_rd);
    chk("s2_imm",     s2_imm,     m_s2_imm);
    chk("s2_ferr",    s2_ferr,    m_s2_ferr);
    chk("s2_illegal", s2_illegal, m_s2_ill);
  endtask

  task automatic model_update();
    int size;
    logic take;
    take = model_takes() && (s1_i16bit || s1_i32bit);
    size = s1_i16bit ? 2 : 4;
    if (cf_valid && cf_ack) begin
      m_v = 0; m_halt = 0; m_pc = cf_target;
    end else if (take) begin
      m_s2_pc  = m_pc;
      m_s2_npc = m_pc + 64'(size);
      m_s2_i16 = s1_i16bit;
      m_s2_rd  = s1_instr[11:7];
      if (s1_i16bit) begin
        m_s2_instr = {16'h0, s1_instr[15:0]};
        m_s2_rs1   = s1_instr[11:7];
        m_s2_rs2   = s1_instr[6:2];
        m_s2_imm   = 0;
        m_s2_ferr  = s1_ferr[0];
        m_s2_ill   = (s1_instr[15:0] == 16'h0);
      end else begin
        m_s2_instr = s1_instr;
        m_s2_rs1   = s1_instr[19:15];
        m_s2_rs2   = s1_instr[24:20];
        m_s2_imm   = ref_imm(s1_instr);
        m_s2_ferr  = (s1_ferr != 2'b00);
        m_s2_ill   = !is_legal(s1_instr[6:2]);
      end
      m_v  = 1;
      m_pc = m_pc + 64'(size);
      if (m_s2_ferr || m_s2_ill) m_halt = 1;
    end else if (s2_ready) begin
      m_v = 0;
    end
  endtask

  task automatic step(input logic cfv, input logic cfa, input logic [63:0] tgt,
                      input logic i16, input logic i32, input logic [31:0] ins,
                      input logic [1:0] fe, input logic rdy);
    @(negedge g_clk);
    cf_valid = cfv; cf_ack = cfa; cf_target = tgt;
    s1_i16bit = i16; s1_i32bit = i32; s1_instr = ins; s1_ferr = fe; s2_ready = rdy;
    #1;
    check_outputs();
    @(posedge g_clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Reset lands mid-cycle with a 32-bit instruction on offer, so gating of the eats is visible.
  task automatic do_reset();
    @(negedge g_clk);
    s1_i32bit = 1; s1_i16bit = 0; s1_instr = 32'h00000013; s2_ready = 1;
    cf_valid = 0; cf_ack = 0;
    #2;
    g_resetn = 0;
    #1;
    chk("rst_valid_async", s2_valid, 0);
    chk("rst_eat4_gated",  s1_eat_4, 0);
    model_reset();
    repeat (2) @(negedge g_clk);
    #1;
    chk("rst_pc",    s2_pc,    0);
    chk("rst_instr", s2_instr, 0);
    chk("rst_eat4",  s1_eat_4, 0);
    @(negedge g_clk);
    s1_i32bit = 0; s1_instr = 0;
    g_resetn = 1;
    idle(3);
  endtask

  logic [31:0] w;
  logic [4:0]  opc;
  logic [31:0] ins;
  logic [63:0] tgt;
  int          kind;

  initial begin
    model_reset();
    do_reset();

    // Sequential 32-bit flow
    step(0, 0, 0, 0, 1, 32'h00500093, 2'b00, 1);
    chk("seq0_pc",  s2_pc,  64'h10000000);
    chk("seq0_imm", s2_imm, 64'd5);
    chk("seq0_rd",  s2_rd,  5'd1);
    chk("seq0_eat4", s1_eat_4, 1);
    step(0, 0, 0, 0, 1, 32'h00208133, 2'b00, 1);
    chk("seq1_pc",  s2_pc,  64'h10000004);
    chk("seq1_rs1", s2_rs1, 5'd1);
    chk("seq1_rs2", s2_rs2, 5'd2);
    chk("seq1_rd",  s2_rd,  5'd2);
    idle(2);

    // Mixed sizes from a fresh reset
    do_reset();
    step(0, 0, 0, 1, 0, 32'h00004505, 2'b00, 1);
    chk("mix0_pc",  s2_pc,  64'h10000000);
    chk("mix0_npc", s2_npc, 64'h10000002);
    step(0, 0, 0, 0, 1, 32'h00000013, 2'b00, 1);
    chk("mix1_pc",  s2_pc,  64'h10000002);
    chk("mix1_npc", s2_npc, 64'h10000006);

    // Back-pressure for three cycles, then resume
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 32'h00100093, 2'b00, 0);
    chk("bp_hold_pc", s2_pc, 64'h10000002);
    chk("bp_no_eat",  s1_eat_4, 0);
    step(0, 0, 0, 0, 1, 32'h00100093, 2'b00, 1);
    step(0, 0, 0, 0, 1, 32'h00100093, 2'b00, 1);
    chk("bp_resume_pc", s2_pc, 64'h1000000A);

    // Flush while stalled
    step(0, 0, 0, 0, 1, 32'h00000013, 2'b00, 0);
    step(1, 1, 64'h80000006, 0, 1, 32'h00000013, 2'b00, 0);
    chk("flush_valid", s2_valid, 0);
    step(0, 0, 0, 0, 1, 32'h00000013, 2'b00, 1);
    chk("flush_pc", s2_pc, 64'h80000006);

    // Fetch fault halts, control-flow change resumes
    step(0, 0, 0, 0, 1, 32'h00000013, 2'b10, 1);
    chk("ferr_flag", s2_ferr, 1);
    step(0, 0, 0, 0, 1, 32'h00000013, 2'b00, 0);
    step(0, 0, 0, 0, 1, 32'h00000013, 2'b00, 1);
    chk("halt_no_eat", s1_eat_4, 0);
    step(1, 1, 64'h80001000, 0, 0, 0, 2'b00, 1);
    step(0, 0, 0, 0, 1, 32'h0000007F, 2'b00, 1);
    chk("ill_flag", s2_illegal, 1);
    chk("ill_pc",   s2_pc,      64'h80001000);
    step(0, 0, 0, 0, 1, 32'h00000013, 2'b00, 1);
    chk("ill_halt_no_eat", s1_eat_4, 0);

    // PC wrap
    step(1, 1, 64'hFFFFFFFFFFFFFFFE, 0, 0, 0, 2'b00, 1);
    step(0, 0, 0, 1, 0, 32'h00004505, 2'b00, 0);
    chk("wrap_pc",  s2_pc,  64'hFFFFFFFFFFFFFFFE);
    chk("wrap_npc", s2_npc, 64'h0);
    chk("pre_reset_valid", s2_valid, 1);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      w    = $urandom;
      opc  = ($urandom_range(0, 9) != 0) ? legal_ops[$urandom_range(0, 12)] : w[6:2];
      kind = $urandom_range(0, 3);
      tgt  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) tgt = 64'hFFFFFFFFFFFFFFF0 | 64'($urandom_range(0, 15));
      tgt[0] = 1'b0;
      if (kind == 1)
        ins = ($urandom_range(0, 9) == 0) ? {w[31:16], 16'h0000} : w;
      else
        ins = {w[31:7], opc, 2'b11};
      step($urandom_range(0, 99) < 8, $urandom_range(0, 3) != 0, tgt,
           kind == 1, kind >= 2, ins,
           ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
